// File: rtl/mod_center_lift.sv
// Streaming centered lift: maps residues in [0,Q) to signed representatives in
// [-(Q-1)/2, Q/2] through a two-stage valid/ready pipeline with boundary and error tagging.
module mod_center_lift #(
    parameter int unsigned W     = 8,
    parameter int unsigned WW    = 2 * W,
    parameter int unsigned Q     = 17,
    parameter int unsigned N     = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [WW-1:0] out_data,
    output logic                 out_last,
    output logic                 out_err,
    output logic                 err_sticky,
    input  logic                 err_clear,
    output logic [CNT_W-1:0]     sample_count
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0]     Q_W      = W'(Q);
    localparam logic [W-1:0]     HALF_W   = W'(Q >> 1);
    localparam logic [WW-1:0]    Q_WW     = WW'(Q);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic             s1_valid_q, s1_valid_d;
    logic [W-1:0]     s1_r_q, s1_r_d;
    logic             s1_err_q, s1_err_d;
    logic             s1_neg_q, s1_neg_d;
    logic             s1_last_q, s1_last_d;
    logic             out_valid_q, out_valid_d;
    logic [WW-1:0]    out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             out_err_q, out_err_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic s2_free;
    logic in_ready_c;
    logic in_fire;
    logic out_fire;
    logic [WW-1:0] r_ext;

    always_comb begin
        s2_free    = !out_valid_q || out_ready;
        in_ready_c = !rst && (!s1_valid_q || s2_free);
        in_fire    = in_valid && in_ready_c;
        out_fire   = out_valid_q && out_ready;
        r_ext      = {{(WW - W){1'b0}}, s1_r_q};

        idx_d        = idx_q;
        s1_valid_d   = s1_valid_q;
        s1_r_d       = s1_r_q;
        s1_err_d     = s1_err_q;
        s1_neg_d     = s1_neg_q;
        s1_last_d    = s1_last_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        out_err_d    = out_err_q;
        err_sticky_d = err_sticky_q;
        cnt_d        = cnt_q;

        if (in_fire) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end

        // S1 loads whenever it can accept; an idle input empties it once it has drained.
        if (in_ready_c) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_r_d    = in_data;
                s1_err_d  = (in_data >= Q_W);
                s1_neg_d  = (in_data < Q_W) && (in_data > HALF_W);
                s1_last_d = (idx_q == LAST_IDX);
            end
        end

        if (s2_free) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_last_d = s1_last_q;
                out_err_d  = s1_err_q;
                if (s1_err_q) begin
                    out_data_d = '0;
                end else if (s1_neg_q) begin
                    out_data_d = r_ext - Q_WW;
                end else begin
                    out_data_d = r_ext;
                end
            end
        end

        // A new error transfer takes priority over a same-cycle clear.
        if (out_fire && out_err_q) begin
            err_sticky_d = 1'b1;
        end else if (err_clear) begin
            err_sticky_d = 1'b0;
        end

        if (out_fire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_r_q       <= '0;
            s1_err_q     <= 1'b0;
            s1_neg_q     <= 1'b0;
            s1_last_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            idx_q        <= idx_d;
            s1_valid_q   <= s1_valid_d;
            s1_r_q       <= s1_r_d;
            s1_err_q     <= s1_err_d;
            s1_neg_q     <= s1_neg_d;
            s1_last_q    <= s1_last_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_err_q    <= out_err_d;
            err_sticky_q <= err_sticky_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready     = in_ready_c;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;
    assign out_err      = out_err_q;
    assign err_sticky   = err_sticky_q;
    assign sample_count = cnt_q;

endmodule

// File: tb/tb_mod_center_lift.sv
// Directed-vector and scoreboard bench for mod_center_lift; Q=17 and Q=16 instances run
// in lockstep on a shared stream, plus a CNT_W=3 instance for counter wrap.
module tb_mod_center_lift;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;
    logic        err_clear;

    logic        in_ready, out_valid, out_last, out_err, err_sticky;
    logic signed [15:0] out_data;
    logic [31:0] sample_count;

    logic        in_ready16, out_valid16, out_last16, out_err16, err_sticky16;
    logic signed [15:0] out_data16;
    logic [31:0] sample_count16;

    logic        in_ready3, out_valid3, out_last3, out_err3, err_sticky3;
    logic signed [15:0] out_data3;
    logic [2:0]  sample_count3;

    always #5 clk = ~clk;

    mod_center_lift #(.W(8), .WW(16), .Q(17), .N(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_err(out_err), .err_sticky(err_sticky),
        .err_clear(err_clear), .sample_count(sample_count)
    );

    mod_center_lift #(.W(8), .WW(16), .Q(16), .N(4), .CNT_W(32)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data),
        .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
        .out_last(out_last16), .out_err(out_err16), .err_sticky(err_sticky16),
        .err_clear(err_clear), .sample_count(sample_count16)
    );

    mod_center_lift #(.W(8), .WW(16), .Q(17), .N(4), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
        .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
        .out_last(out_last3), .out_err(out_err3), .err_sticky(err_sticky3),
        .err_clear(err_clear), .sample_count(sample_count3)
    );

    typedef struct {
        logic [7:0]  din;
        logic [15:0] d17;
        logic        e17;
        logic [15:0] d16;
        logic        e16;
    } vec_t;

    typedef struct {
        logic [15:0] d17;
        logic        e17;
        logic        last;
        logic [15:0] d16;
        logic        e16;
        int          acc_cyc;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   idx_m = 0;
    bit   lat_on = 1'b0;
    bit   rand_rdy = 1'b0;
    exp_t q[$];
    vec_t vec[10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] center(input logic [7:0] r, input int unsigned qm);
        if (r >= qm) return 16'h0;
        else if (r > (qm >> 1)) return 16'(r) - 16'(qm);
        else return 16'(r);
    endfunction

    function automatic vec_t model_vec(input logic [7:0] r);
        vec_t v;
        v.din = r;
        v.d17 = center(r, 17);
        v.e17 = (r >= 17);
        v.d16 = center(r, 16);
        v.e16 = (r >= 16);
        return v;
    endfunction

    task automatic send(input vec_t v);
        int n;
        exp_t e;
        n = 0;
        in_valid = 1'b1;
        in_data  = v.din;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            chk("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            e.d17 = v.d17; e.e17 = v.e17; e.d16 = v.d16; e.e16 = v.e16;
            e.last = (idx_m == 3);
            e.acc_cyc = cyc;
            idx_m = (idx_m + 1) % 4;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Random backpressure driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Output scoreboard and stall-stability monitor.
    initial begin
        bit          hold_v;
        logic [15:0] hold_d;
        logic        hold_l, hold_e;
        exp_t        e;
        hold_v = 1'b0;
        hold_d = '0; hold_l = 1'b0; hold_e = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = 1'b0;
                n_out  = 0;
                q.delete();
            end else begin
                if (hold_v) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_data", {16'h0, out_data}, {16'h0, hold_d});
                    chk("stall_last_err", {30'h0, out_last, out_err}, {30'h0, hold_l, hold_e});
                end
                hold_v = out_valid && !out_ready;
                hold_d = out_data; hold_l = out_last; hold_e = out_err;
                if (out_valid && out_ready) begin
                    n_out++;
                    if (q.size() == 0) begin
                        chk("unexpected_output", 32'(q.size()), 32'd1);
                    end else begin
                        e = q.pop_front();
                        chk("data17", {16'h0, out_data}, {16'h0, e.d17});
                        chk("err17", 32'(out_err), 32'(e.e17));
                        chk("last", 32'(out_last), 32'(e.last));
                        chk("valid16", 32'(out_valid16), 32'd1);
                        chk("data16", {16'h0, out_data16}, {16'h0, e.d16});
                        chk("err16", 32'(out_err16), 32'(e.e16));
                        if (lat_on) chk("latency", 32'(cyc - e.acc_cyc), 32'd2);
                    end
                end
            end
        end
    end

    initial begin
        vec[0] = '{8'd0,   16'd0,      1'b0, 16'd0,      1'b0};
        vec[1] = '{8'd1,   16'd1,      1'b0, 16'd1,      1'b0};
        vec[2] = '{8'd8,   16'd8,      1'b0, 16'd8,      1'b0};
        vec[3] = '{8'd9,   16'hFFF8,   1'b0, 16'hFFF9,   1'b0};
        vec[4] = '{8'd16,  16'hFFFF,   1'b0, 16'd0,      1'b1};
        vec[5] = '{8'd8,   16'd8,      1'b0, 16'd8,      1'b0};
        vec[6] = '{8'd9,   16'hFFF8,   1'b0, 16'hFFF9,   1'b0};
        vec[7] = '{8'd15,  16'hFFFE,   1'b0, 16'hFFFF,   1'b0};
        vec[8] = '{8'd17,  16'd0,      1'b1, 16'd0,      1'b1};
        vec[9] = '{8'd255, 16'd0,      1'b1, 16'd0,      1'b1};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; err_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", {16'h0, out_data}, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_flags", {29'h0, out_last, out_err, err_sticky}, 32'd0);
        chk("rst_count", sample_count, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic stream with latency check.
        out_ready = 1'b1;
        lat_on = 1'b1;
        for (int i = 0; i < 5; i++) send(vec[i]);
        drain();
        lat_on = 1'b0;
        chk("count_after_5", sample_count, 32'd5);
        chk("count3_after_5", 32'(sample_count3), 32'd5);
        chk("sticky_clean", 32'(err_sticky), 32'd0);

        for (int i = 5; i < 10; i++) send(vec[i]);
        drain();
        chk("sticky_set", 32'(err_sticky), 32'd1);
        send(model_vec(8'd3));
        drain();
        chk("sticky_hold", 32'(err_sticky), 32'd1);

        // Clear alone.
        @(posedge clk); #1; err_clear = 1'b1;
        @(posedge clk); #1; err_clear = 1'b0;
        chk("sticky_cleared", 32'(err_sticky), 32'd0);

        // Clear coinciding with an error transfer: set wins.
        out_ready = 1'b0;
        send(model_vec(8'd200));
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!out_valid && n < 20);
            chk("err_stall_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1; out_ready = 1'b1; err_clear = 1'b1;
        @(posedge clk); #1; err_clear = 1'b0;
        chk("sticky_set_wins", 32'(err_sticky), 32'd1);
        drain();
        @(posedge clk); #1; err_clear = 1'b1;
        @(posedge clk); #1; err_clear = 1'b0;

        // Random traffic and backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 15) == 0) send(model_vec(8'($urandom_range(17, 255))));
                else send(model_vec(8'($urandom_range(0, 16))));
            end else begin
                @(posedge clk); #1;
            end
        end
        drain();
        chk("count_after_random", sample_count, 32'(n_out));

        // Reset with two samples in flight.
        out_ready = 1'b0;
        send(model_vec(8'd5));
        send(model_vec(8'd6));
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_count", sample_count, 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        idx_m = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send(model_vec(8'(i)));
        drain();
        chk("count_after_rst", sample_count, 32'd4);
        for (int i = 10; i < 15; i++) send(model_vec(8'(i)));
        drain();
        chk("count_9", sample_count, 32'd9);
        chk("count3_wrap", 32'(sample_count3), 32'd1);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
